// File: rtl/fetch_unit_if.sv
// Purpose: bundles the controller strobes, memory data and fetch results of fetch_unit.
// Latency: none. This file only carries wires.
// Backpressure: none. Strobes are single-cycle commands and are never stalled.
// Ports (modports):
//   master : drives fetch, load_ir, inc_pc, load_pc, halt, data_in; observes the results
//   slave  : the fetch unit; observes the strobes and drives addr, pc, opcode, ir_addr,
//            ir_valid, halted (and instr_cnt when FETCH_STATS_EN is defined)
interface fetch_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13,
  parameter int OPC_W  = 3
);
  logic              fetch;
  logic              load_ir;
  logic              inc_pc;
  logic              load_pc;
  logic              halt;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] pc;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic              ir_valid;
  logic              halted;
`ifdef FETCH_STATS_EN
  logic [15:0]       instr_cnt;
`endif

  modport master (
    output fetch, load_ir, inc_pc, load_pc, halt, data_in,
`ifdef FETCH_STATS_EN
    input  instr_cnt,
`endif
    input  addr, pc, opcode, ir_addr, ir_valid, halted
  );

  modport slave (
    input  fetch, load_ir, inc_pc, load_pc, halt, data_in,
`ifdef FETCH_STATS_EN
    output instr_cnt,
`endif
    output addr, pc, opcode, ir_addr, ir_valid, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Purpose: program counter, two-byte instruction register and memory address mux.
// Latency: addr is combinational. pc, IR, ir_valid and halted update on the edge after a strobe.
// Backpressure: none. Strobes act on every edge unless halted; halt freezes state until i_rst.
// Ports:
//   i_clk  : clock, all state changes on the rising edge
//   i_rst  : synchronous active-high reset, overrides every strobe
//   bus    : fetch_unit_if.slave (strobes and data_in in; addr/pc/opcode/ir_addr/ir_valid/halted out)
// Optional feature: define FETCH_STATS_EN to add bus.instr_cnt, a saturating count of completed
//   instruction fetches (low-byte captures), cleared by reset and frozen while halted.
module fetch_unit #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 13,
  parameter int                OPC_W    = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  fetch_unit_if.slave  bus
);
  localparam int                IR_W   = OPC_W + ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  // The IR is filled as exactly two data-bus bytes.
  generate
    if (2 * DATA_W != IR_W) begin : g_bad_width
      $error("fetch_unit: 2*DATA_W must equal OPC_W+ADDR_W");
    end
  endgenerate

  typedef enum logic {PTR_HI, PTR_LO} ptr_t;

  ptr_t              r_ptr;
  logic [IR_W-1:0]   r_ir;
  logic [ADDR_W-1:0] r_pc;
  logic              r_ir_valid;
  logic              r_halted;
`ifdef FETCH_STATS_EN
  logic [15:0]       r_instr_cnt;
`endif

  // A halt request blocks the strobes on the very edge it is sampled, not just afterwards.
  logic w_active;
  assign w_active = !r_halted && !bus.halt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= PTR_HI;
      r_ir        <= '0;
      r_pc        <= RESET_PC;
      r_ir_valid  <= 1'b0;
      r_halted    <= 1'b0;
`ifdef FETCH_STATS_EN
      r_instr_cnt <= '0;
`endif
    end else begin
      if (bus.halt) begin
        r_halted <= 1'b1;
      end

      if (w_active) begin
        case (r_ptr)
          PTR_HI: begin
            if (bus.load_ir) begin
              r_ir[IR_W-1 -: DATA_W] <= bus.data_in;
              r_ir_valid             <= 1'b0;
              r_ptr                  <= PTR_LO;
            end
          end
          PTR_LO: begin
            // Without a low byte the pending high byte is orphaned; the next
            // load_ir starts a fresh instruction and ir_valid stays low.
            r_ptr <= PTR_HI;
            if (bus.load_ir) begin
              r_ir[DATA_W-1:0] <= bus.data_in;
              r_ir_valid       <= 1'b1;
`ifdef FETCH_STATS_EN
              if (r_instr_cnt != 16'hFFFF) begin
                r_instr_cnt <= r_instr_cnt + 16'd1;
              end
`endif
            end
          end
          default: r_ptr <= PTR_HI;
        endcase

        // Jump beats increment; the jump target is the IR as it stood before this edge.
        if (bus.load_pc) begin
          r_pc <= r_ir[ADDR_W-1:0];
        end else if (bus.inc_pc) begin
          r_pc <= r_pc + PC_ONE;
        end
      end
    end
  end

  assign bus.pc       = r_pc;
  assign bus.opcode   = r_ir[IR_W-1 -: OPC_W];
  assign bus.ir_addr  = r_ir[ADDR_W-1:0];
  assign bus.ir_valid = r_ir_valid;
  assign bus.halted   = r_halted;
  assign bus.addr     = bus.fetch ? r_pc : r_ir[ADDR_W-1:0];
`ifdef FETCH_STATS_EN
  assign bus.instr_cnt = r_instr_cnt;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: directed self-checking bench for fetch_unit.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: not applicable.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.DATA_W(8), .ADDR_W(13), .OPC_W(3)) bus ();

  fetch_unit #(.DATA_W(8), .ADDR_W(13), .OPC_W(3), .RESET_PC(13'h0)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input logic [7:0] hi, input logic [7:0] lo);
    bus.load_ir = 1'b1;
    bus.data_in = hi;
    tick();
    bus.data_in = lo;
    tick();
    bus.load_ir = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.fetch   = 1'b1;
    bus.load_ir = 1'b0;
    bus.inc_pc  = 1'b0;
    bus.load_pc = 1'b0;
    bus.halt    = 1'b0;
    bus.data_in = 8'h00;
    #1;

    // Reset state
    do_reset();
    check("rst_pc",       32'(bus.pc),       32'h0);
    check("rst_opcode",   32'(bus.opcode),   32'h0);
    check("rst_ir_addr",  32'(bus.ir_addr),  32'h0);
    check("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
    check("rst_halted",   32'(bus.halted),   32'h0);
    check("rst_addr",     32'(bus.addr),     32'h0);

    // Two-byte capture: A1,23 -> opcode 101, ir_addr 0123
    bus.load_ir = 1'b1;
    bus.data_in = 8'hA1;
    tick();
    check("hi_ir_valid",  32'(bus.ir_valid), 32'h0);
    bus.data_in = 8'h23;
    tick();
    bus.load_ir = 1'b0;
    check("pair_opcode",   32'(bus.opcode),   32'h5);
    check("pair_ir_addr",  32'(bus.ir_addr),  32'h0123);
    check("pair_ir_valid", 32'(bus.ir_valid), 32'h1);
    bus.fetch = 1'b0;
    #1;
    check("addr_from_ir", 32'(bus.addr), 32'h0123);
    bus.fetch = 1'b1;

    // PC wrap: jump to 1FFF then increment
    load_pair(8'h1F, 8'hFF);
    bus.load_pc = 1'b1;
    tick();
    bus.load_pc = 1'b0;
    check("jump_1fff", 32'(bus.pc), 32'h1FFF);
    bus.inc_pc = 1'b1;
    tick();
    bus.inc_pc = 1'b0;
    check("wrap_pc",   32'(bus.pc),   32'h0);
    check("wrap_addr", 32'(bus.addr), 32'h0);
    tick();
    check("hold_pc",   32'(bus.pc),   32'h0);

    // load_pc beats inc_pc, target from IR E0AB
    load_pair(8'hE0, 8'hAB);
    check("e0ab_opcode", 32'(bus.opcode), 32'h7);
`ifdef FETCH_STATS_EN
    check("cnt_3", 32'(bus.instr_cnt), 32'd3);
`endif
    bus.load_pc = 1'b1;
    bus.inc_pc  = 1'b1;
    tick();
    bus.load_pc = 1'b0;
    bus.inc_pc  = 1'b0;
    check("jump_prio_pc", 32'(bus.pc), 32'h00AB);
    bus.fetch = 1'b0;
    #1;
    check("jump_prio_addr", 32'(bus.addr), 32'h00AB);
    bus.fetch = 1'b1;
    bus.inc_pc = 1'b1;
    tick();
    bus.inc_pc = 1'b0;
    check("inc_pc", 32'(bus.pc), 32'h00AC);

    // Orphan high byte, idle, then a clean pair
    bus.load_ir = 1'b1;
    bus.data_in = 8'hFF;
    tick();
    bus.load_ir = 1'b0;
    tick();
    check("orphan_ir_valid", 32'(bus.ir_valid), 32'h0);
    load_pair(8'h40, 8'h05);
    check("orphan_opcode",   32'(bus.opcode),   32'h2);
    check("orphan_ir_addr",  32'(bus.ir_addr),  32'h0005);
    check("orphan_ir_valid2", 32'(bus.ir_valid), 32'h1);

    // Three back-to-back bytes: 12 hi, 34 lo, 56 hi again
    bus.load_ir = 1'b1;
    bus.data_in = 8'h12;
    tick();
    bus.data_in = 8'h34;
    tick();
    check("b2b_ir_addr1", 32'(bus.ir_addr), 32'h1234);
    bus.data_in = 8'h56;
    tick();
    bus.load_ir = 1'b0;
    check("b2b_opcode",   32'(bus.opcode),   32'h2);
    check("b2b_ir_addr",  32'(bus.ir_addr),  32'h1634);
    check("b2b_ir_valid", 32'(bus.ir_valid), 32'h0);
    tick();

    // Halt at pc 0010, strobes then ignored
    load_pair(8'h00, 8'h10);
    bus.load_pc = 1'b1;
    tick();
    bus.load_pc = 1'b0;
    check("pc_0010", 32'(bus.pc), 32'h0010);
    bus.halt   = 1'b1;
    bus.inc_pc = 1'b1;
    tick();
    bus.halt   = 1'b0;
    check("halt_edge_pc", 32'(bus.pc),     32'h0010);
    check("halted_set",   32'(bus.halted), 32'h1);
    tick();
    bus.inc_pc  = 1'b0;
    bus.load_ir = 1'b1;
    bus.data_in = 8'hC7;
    tick();
    bus.load_ir = 1'b0;
    bus.load_pc = 1'b1;
    tick();
    bus.load_pc = 1'b0;
    check("halt_pc",       32'(bus.pc),       32'h0010);
    check("halt_sticky",   32'(bus.halted),   32'h1);
    check("halt_ir_valid", 32'(bus.ir_valid), 32'h1);
    check("halt_ir_addr",  32'(bus.ir_addr),  32'h0010);
    bus.fetch = 1'b0;
    #1;
    check("halt_addr", 32'(bus.addr), 32'h0010);
    bus.fetch = 1'b1;
`ifdef FETCH_STATS_EN
    check("cnt_halt", 32'(bus.instr_cnt), 32'd6);
`endif
    do_reset();
    check("unhalt",     32'(bus.halted), 32'h0);
    check("unhalt_pc",  32'(bus.pc),     32'h0);
`ifdef FETCH_STATS_EN
    check("cnt_rst", 32'(bus.instr_cnt), 32'd0);
`endif

    // Reset beats a same-cycle load_ir
    bus.load_ir = 1'b1;
    bus.data_in = 8'h5A;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.load_ir = 1'b0;
    check("rst_wins_opcode",  32'(bus.opcode),  32'h0);
    check("rst_wins_ir_addr", 32'(bus.ir_addr), 32'h0);

    // Reset mid-instruction returns the byte pointer to HI
    bus.load_ir = 1'b1;
    bus.data_in = 8'h5A;
    tick();
    bus.load_ir = 1'b0;
    do_reset();
    load_pair(8'hA1, 8'h23);
    check("mid_rst_opcode",  32'(bus.opcode),  32'h5);
    check("mid_rst_ir_addr", 32'(bus.ir_addr), 32'h0123);
    check("mid_rst_valid",   32'(bus.ir_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
